// File: rtl/store_pkg.sv
// Shared size codes and the FIFO entry layout for the store buffer.
// Entry fields are sized for the widest supported bus and address.
package store_pkg;

    localparam logic [1:0] SZ_FULL = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam int unsigned SB_MAX_ADDR_W = 64;
    localparam int unsigned SB_MAX_DATA_W = 64;
    localparam int unsigned SB_MAX_BYTES  = SB_MAX_DATA_W / 8;

    typedef struct packed {
        logic [SB_MAX_ADDR_W-1:0] addr;
        logic [SB_MAX_BYTES-1:0]  be;
        logic [SB_MAX_DATA_W-1:0] wdata;
    } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// Converts a store request into a byte-enable mask and lane-aligned data,
// flagging offsets that are illegal for the requested size.
module store_align
    import store_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]                    in_size,
    input  logic [$clog2(DATA_W/8)-1:0]   in_addr,
    input  logic [DATA_W-1:0]             in_data,
    output logic [DATA_W/8-1:0]           be,
    output logic [DATA_W-1:0]             wdata,
    output logic                          err
);

    localparam int unsigned BYTES = DATA_W / 8;

    always_comb begin
        be  = '0;
        err = 1'b0;
        case (in_size)
            SZ_FULL: begin
                if (in_addr != '0) err = 1'b1;
                else               be  = '1;
            end
            SZ_HALF: begin
                if (in_addr[0]) err = 1'b1;
                else            be  = BYTES'(2'b11) << in_addr;
            end
            SZ_WORD: begin
                // word size only exists on the 64-bit bus
                if (DATA_W != 64 || in_addr[1:0] != 2'b00) err = 1'b1;
                else                                      be  = BYTES'(4'hF) << in_addr;
            end
            default: be = BYTES'(1) << in_addr;
        endcase
        wdata = in_data << {in_addr, 3'b000};
    end

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: aligns requests, queues them in a DEPTH-entry FIFO,
// drains to memory over valid/ready and reports load-address hits.
module store_buffer
    import store_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_size,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       misalign,
    output logic [ADDR_W-1:0]          err_addr,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W/8-1:0]        mem_be,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    sb_entry_t         entries [DEPTH];
    sb_entry_t         new_entry;
    sb_entry_t         head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [BYTES-1:0]  al_be;
    logic [DATA_W-1:0] al_wdata;
    logic              al_err;
    logic              accept;
    logic              do_push;
    logic              do_drop;
    logic              do_pop;
    logic              head_unused;

    store_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .in_size (in_size),
        .in_addr (in_addr[OFF_W-1:0]),
        .in_data (in_data),
        .be      (al_be),
        .wdata   (al_wdata),
        .err     (al_err)
    );

    assign in_ready  = (count_q != FULL_CNT);
    assign mem_valid = (count_q != '0);
    assign count     = count_q;

    assign accept  = in_valid && in_ready;
    assign do_push = accept && !al_err;
    assign do_drop = accept && al_err;
    assign do_pop  = mem_valid && mem_ready;

    always_comb begin
        new_entry       = '0;
        new_entry.addr  = SB_MAX_ADDR_W'(in_addr & ALIGN_MASK);
        new_entry.be    = SB_MAX_BYTES'(al_be);
        new_entry.wdata = SB_MAX_DATA_W'(al_wdata);
    end

    assign head      = entries[rd_ptr];
    assign mem_addr  = head.addr[ADDR_W-1:0];
    assign mem_be    = head.be[BYTES-1:0];
    assign mem_wdata = head.wdata[DATA_W-1:0];
    // Upper entry bits beyond this instance's widths are always zero.
    assign head_unused = ^(head.addr >> ADDR_W) ^ ^(head.be >> BYTES) ^ ^(head.wdata >> DATA_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            misalign <= 1'b0;
            err_addr <= '0;
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= new_entry;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            misalign <= do_drop;
            if (do_drop) begin
                err_addr <= in_addr;
            end
        end
    end

    // An entry is occupied when its distance from the read pointer is below count.
    always_comb begin
        logic [PTR_W-1:0]         rel;
        logic [SB_MAX_ADDR_W-1:0] ld_tag;
        rel    = '0;
        ld_tag = SB_MAX_ADDR_W'(ld_addr & ALIGN_MASK);
        ld_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rel = PTR_W'(i) - rd_ptr;
            if (({1'b0, rel} < count_q) && (entries[i].addr == ld_tag)) begin
                ld_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: 32-bit instance with a drain-order
// scoreboard plus a 64-bit instance for the word/full-width lane cases.
module tb_store_buffer;

    localparam logic [1:0] S_FULL = 2'b00;
    localparam logic [1:0] S_HALF = 2'b01;
    localparam logic [1:0] S_BYTE = 2'b10;
    localparam logic [1:0] S_WORD = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_size = 2'b00;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic        misalign;
    logic [31:0] err_addr;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] ld_addr = '0;
    logic        ld_hit;
    logic [2:0]  count;

    logic        in64_valid = 1'b0;
    logic        in64_ready;
    logic [1:0]  in64_size = 2'b00;
    logic [31:0] in64_addr = '0;
    logic [63:0] in64_data = '0;
    logic        misalign64;
    logic [31:0] err_addr64;
    logic        mem64_valid;
    logic        mem64_ready = 1'b0;
    logic [31:0] mem64_addr;
    logic [7:0]  mem64_be;
    logic [63:0] mem64_wdata;
    logic [31:0] ld64_addr = '0;
    logic        ld64_hit;
    logic [2:0]  count64;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_pop;
    exp_t        mon_push;
    logic        mon_ok;

    always #5 clk = ~clk;

    store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_size(in_size),
        .in_addr(in_addr), .in_data(in_data),
        .misalign(misalign), .err_addr(err_addr),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .count(count)
    );

    store_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in64_valid), .in_ready(in64_ready), .in_size(in64_size),
        .in_addr(in64_addr), .in_data(in64_data),
        .misalign(misalign64), .err_addr(err_addr64),
        .mem_valid(mem64_valid), .mem_ready(mem64_ready), .mem_addr(mem64_addr),
        .mem_be(mem64_be), .mem_wdata(mem64_wdata),
        .ld_addr(ld64_addr), .ld_hit(ld64_hit), .count(count64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference lane model for the 32-bit bus, built byte by byte.
    function automatic void model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                  output logic ok, output exp_t e);
        int unsigned off;
        int unsigned n;
        off = a % 4;
        case (sz)
            S_FULL:  n = 4;
            S_HALF:  n = 2;
            S_BYTE:  n = 1;
            default: n = 0;
        endcase
        ok     = (n != 0) && (off % n == 0);
        e.addr = a & 32'hFFFF_FFFC;
        e.be   = '0;
        e.wd   = '0;
        if (ok) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (b >= off && b < off + n) begin
                    e.be[b]       = 1'b1;
                    e.wd[b*8 +: 8] = d[(b-off)*8 +: 8];
                end
            end
        end
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int unsigned b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
        return m;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (mem_valid && mem_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_pop = sb.pop_front();
                    check("sb_addr", 64'(mem_addr), 64'(mon_pop.addr));
                    check("sb_be", 64'(mem_be), 64'(mon_pop.be));
                    check("sb_wdata", 64'(mem_wdata & lane_mask(mon_pop.be)), 64'(mon_pop.wd));
                end
            end
            if (in_valid && in_ready) begin
                model(in_size, in_addr, in_data, mon_ok, mon_push);
                if (mon_ok) sb.push_back(mon_push);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        in_size  = sz;
        in_addr  = a;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        reset = 1'b0;
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        check("rst_err_addr", 64'(err_addr), 64'd0);
        check("rst_ld_hit", 64'(ld_hit), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_be", 64'(mem_be), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);

        // byte store at 0x103, visible only after the accepting edge
        in_valid = 1'b1; in_size = S_BYTE; in_addr = 32'h103; in_data = 32'hAB;
        @(negedge clk);
        check("byte_pre_valid", 64'(mem_valid), 64'd0);
        step();
        in_valid = 1'b0;
        check("byte_valid", 64'(mem_valid), 64'd1);
        check("byte_be", 64'(mem_be), 64'h8);
        check("byte_addr", 64'(mem_addr), 64'h100);
        check("byte_lane", 64'(mem_wdata[31:24]), 64'hAB);
        check("byte_count", 64'(count), 64'd1);
        mem_ready = 1'b1; step(); mem_ready = 1'b0;
        check("byte_drained", 64'(mem_valid), 64'd0);

        drive(S_HALF, 32'h102, 32'h1234);
        check("half_be", 64'(mem_be), 64'hC);
        mem_ready = 1'b1; step(); mem_ready = 1'b0;

        drive(S_HALF, 32'h101, 32'h5678);
        check("mis_half_count", 64'(count), 64'd0);
        check("mis_half_pulse", 64'(misalign), 64'd1);
        check("mis_half_addr", 64'(err_addr), 64'h101);
        step();
        check("mis_pulse_end", 64'(misalign), 64'd0);
        drive(S_WORD, 32'h100, 32'h0);
        check("mis_word32", 64'(misalign), 64'd1);
        check("mis_word32_addr", 64'(err_addr), 64'h100);

        // back-to-back errors give consecutive pulses
        in_valid = 1'b1; in_size = S_HALF; in_addr = 32'h105;
        step();
        check("b2b_pulse0", 64'(misalign), 64'd1);
        check("b2b_addr0", 64'(err_addr), 64'h105);
        in_size = S_FULL; in_addr = 32'h107;
        step();
        in_valid = 1'b0;
        check("b2b_pulse1", 64'(misalign), 64'd1);
        check("b2b_addr1", 64'(err_addr), 64'h107);
        step();
        check("b2b_end", 64'(misalign), 64'd0);

        // fill to DEPTH with memory stalled
        for (int i = 0; i < 4; i++) drive(S_FULL, 32'h10 + 32'(4*i), $urandom);
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_size = S_HALF; in_addr = 32'h21;
        step();
        check("full_err_nopulse", 64'(misalign), 64'd0);
        in_size = S_FULL; in_addr = 32'h50; in_data = 32'hCAFEF00D;
        step();
        check("full_held_count", 64'(count), 64'd4);
        check("full_held_ready", 64'(in_ready), 64'd0);
        mem_ready = 1'b1; step(); mem_ready = 1'b0;
        check("full_pop_count", 64'(count), 64'd3);
        check("full_pop_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("full_refill", 64'(count), 64'd4);
        mem_ready = 1'b1; repeat (4) step(); mem_ready = 1'b0;
        check("full_drained", 64'(count), 64'd0);

        // simultaneous push/pop at count 2, wrapping the pointers
        drive(S_FULL, 32'h300, $urandom);
        drive(S_FULL, 32'h304, $urandom);
        mem_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_size  = (k % 3 == 0) ? S_FULL : ((k % 3 == 1) ? S_HALF : S_BYTE);
            in_addr  = 32'h400 + 32'(4*k) + ((k % 3 == 1) ? 32'd2 : ((k % 3 == 2) ? 32'(k % 4) : 32'd0));
            in_data  = $urandom;
            step();
            check("pp_count", 64'(count), 64'd2);
        end
        in_valid = 1'b0;
        step(); step();
        mem_ready = 1'b0;
        check("pp_drained", 64'(count), 64'd0);

        // load hit against a pending store
        ld_addr = 32'h202;
        in_valid = 1'b1; in_size = S_FULL; in_addr = 32'h200; in_data = 32'h77;
        @(negedge clk);
        check("ld_pre_push", 64'(ld_hit), 64'd0);
        step();
        in_valid = 1'b0;
        check("ld_hit", 64'(ld_hit), 64'd1);
        ld_addr = 32'h204; #1;
        check("ld_other_word", 64'(ld_hit), 64'd0);
        ld_addr = 32'h202; #1;
        mem_ready = 1'b1; step(); mem_ready = 1'b0;
        check("ld_after_pop", 64'(ld_hit), 64'd0);

        // reset with entries queued and an error request in flight
        drive(S_FULL, 32'h200, $urandom);
        drive(S_FULL, 32'h204, $urandom);
        drive(S_FULL, 32'h208, $urandom);
        check("pre_rst_count", 64'(count), 64'd3);
        reset = 1'b1; in_valid = 1'b1; in_size = S_HALF; in_addr = 32'h211;
        step();
        reset = 1'b0; in_valid = 1'b0;
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_valid", 64'(mem_valid), 64'd0);
        check("mid_rst_misalign", 64'(misalign), 64'd0);
        check("mid_rst_ld_hit", 64'(ld_hit), 64'd0);
        step();
        check("post_rst_valid", 64'(mem_valid), 64'd0);

        // 64-bit bus lanes
        in64_valid = 1'b1; in64_size = S_WORD; in64_addr = 32'h04; in64_data = 64'hDEADBEEF;
        step();
        in64_valid = 1'b0;
        check("w64_be", 64'(mem64_be), 64'hF0);
        check("w64_lane", 64'(mem64_wdata[63:32]), 64'hDEADBEEF);
        check("w64_addr", 64'(mem64_addr), 64'h0);
        mem64_ready = 1'b1; step(); mem64_ready = 1'b0;
        in64_valid = 1'b1; in64_size = S_WORD; in64_addr = 32'h02;
        step();
        in64_valid = 1'b0;
        check("w64_mis", 64'(misalign64), 64'd1);
        check("w64_mis_addr", 64'(err_addr64), 64'h2);
        check("w64_mis_count", 64'(count64), 64'd0);
        in64_valid = 1'b1; in64_size = S_FULL; in64_addr = 32'h00; in64_data = 64'h1122334455667788;
        step();
        in64_valid = 1'b0;
        check("f64_be", 64'(mem64_be), 64'hFF);
        check("f64_wdata", mem64_wdata, 64'h1122334455667788);
        mem64_ready = 1'b1; step(); mem64_ready = 1'b0;

        check("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
